dcache_flush_seq: RTL
=====================

Name: dcache_flush_seq

Overview:
- Walks every set of the write-back data cache when the flush controller requests a full D$ flush (fence / fence.i).
- Writes back each valid+dirty way, then invalidates the set.
- Returns a single-cycle acknowledge that clears the controller's fence-active state.
- Sits directly downstream of the flush controller's registered flush_dcache output, between it and the cache tag array / write-back unit.

Parameters:
- NUM_SETS, 256, number of cache sets (power of two, >=2)
- NUM_WAYS, 8, associativity (power of two, >=2)
- IDX_W, $clog2(NUM_SETS), set index width (derived)
- WAY_W, $clog2(NUM_WAYS), way index width (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  flush request level from controller; held high until ack
- flush_ack_o  out  1  one-cycle pulse: flush complete
- busy_o  out  1  high in every state except IDLE
- tag_req_o  out  1  tag/status read request
- tag_idx_o  out  IDX_W  set index for read
- tag_gnt_i  in  1  read accepted
- tag_rvalid_i  in  1  read data valid, exactly one cycle after gnt
- valid_i  in  NUM_WAYS  per-way valid bits, sampled on tag_rvalid_i
- dirty_i  in  NUM_WAYS  per-way dirty bits, sampled on tag_rvalid_i
- wb_req_o  out  1  write-back request
- wb_idx_o  out  IDX_W  write-back set
- wb_way_o  out  WAY_W  write-back way
- wb_gnt_i  in  1  write-back accepted
- wb_done_i  in  1  write-back finished (pulse)
- inval_req_o  out  1  clear valid/dirty of all ways in set
- inval_idx_o  out  IDX_W  invalidate set
- inval_gnt_i  in  1  invalidate accepted, completes same cycle
- wb_count_o  out  16  lines written back in current/last flush, saturating

Behaviour:
- Reset: state IDLE, idx=0, mask=0, wb_count_o=0; all outputs 0. Reset mid-flush aborts immediately; no ack is issued.
- Requests follow req/gnt: req and its idx/way stay stable until gnt. The transfer occurs in the gnt cycle. gnt without req is ignored.
- State machine:
  - IDLE: if flush_i and not holdoff -> idx=0, wb_count_o=0, go READ_TAG.
  - READ_TAG: tag_req_o=1, tag_idx_o=idx; on tag_gnt_i -> WAIT_TAG.
  - WAIT_TAG: on tag_rvalid_i, mask = valid_i & dirty_i; mask!=0 -> WRITEBACK, else -> INVALIDATE.
  - WRITEBACK: wb_req_o=1, wb_way_o = lowest set bit of mask; on wb_gnt_i -> WAIT_WB.
  - WAIT_WB: on wb_done_i, clear that mask bit and increment wb_count_o (saturate at 16'hFFFF). Then updated mask!=0 -> WRITEBACK, else -> INVALIDATE. wb_done_i is ignored in all other states.
  - INVALIDATE: inval_req_o=1, inval_idx_o=idx; on inval_gnt_i -> NEXT_SET.
  - NEXT_SET: idx==NUM_SETS-1 -> DONE; else idx+1 -> READ_TAG. idx never wraps during a flush.
  - DONE: flush_ack_o=1 for exactly this cycle -> IDLE.
- Holdoff: flush_i is ignored in the first IDLE cycle after DONE. This absorbs the controller's one-cycle registered flush_dcache latency. A flush_i still high on the second IDLE cycle starts a new flush.
- flush_i deasserting mid-flush does not abort; the walk completes and acks.
- Ways with valid=1, dirty=0 and invalid ways are never written back. Every set is invalidated regardless of contents.
- Latency, zero-wait grants:
  - 4 cycles per clean set.
  - +2 cycles per dirty line, with wb_done_i one cycle after wb_gnt_i.
  - flush_i rising in cycle 0 gives ack in cycle 1 + 4*NUM_SETS + 2*(dirty lines).
- wb_count_o holds its value after ack until the next flush start.

Test Plan:
- NUM_SETS=4, NUM_WAYS=2, all grants immediate, valid=dirty=0 everywhere, flush_i rises in cycle 0 -> inval_idx_o 0,1,2,3 in order, no wb_req_o, flush_ack_o pulses only in cycle 17, wb_count_o=0.
- Set 2 returns valid=2'b11, dirty=2'b10; set 3 returns valid=2'b01, dirty=2'b01 -> write-backs (idx2, way1) then (idx3, way0); wb_count_o=2; ack in cycle 21.
- Same as the previous case with tag_gnt_i, wb_gnt_i and inval_gnt_i each held low 3 cycles -> req/idx/way stable throughout the stalls, same write-back order, ack delayed accordingly; wb_done_i pulsed during WRITEBACK is ignored.
- rst_i asserted while in WAIT_WB at idx=1 -> all outputs 0 immediately, no ack; a new flush_i restarts from idx=0 with wb_count_o cleared.
- flush_i held high 3 cycles past the ack -> no new flush in the cycle after ack; a second flush starts the following cycle (busy_o=1).
- wb_count_o preloaded near 16'hFFFE via a prior long flush with force -> saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/dcache_flush_seq_if.sv
// rtl/dcache_flush_seq_if.sv - flush request, tag read, write-back and invalidate bundle for the D$ flush walker
interface dcache_flush_seq_if #(
   parameter int NUM_SETS = 256,
   parameter int NUM_WAYS = 8
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);

   // flush controller side
   logic                flush_i;
   logic                flush_ack_o;
   logic                busy_o;

   // tag/status array read port
   logic                tag_req_o;
   logic [IDX_W-1:0]    tag_idx_o;
   logic                tag_gnt_i;
   logic                tag_rvalid_i;
   logic [NUM_WAYS-1:0] valid_i;
   logic [NUM_WAYS-1:0] dirty_i;

   // write-back unit
   logic                wb_req_o;
   logic [IDX_W-1:0]    wb_idx_o;
   logic [WAY_W-1:0]    wb_way_o;
   logic                wb_gnt_i;
   logic                wb_done_i;

   // set invalidate port
   logic                inval_req_o;
   logic [IDX_W-1:0]    inval_idx_o;
   logic                inval_gnt_i;

   // statistics
   logic [15:0]         wb_count_o;

   // sequencer view
   modport master (
      input  flush_i, tag_gnt_i, tag_rvalid_i, valid_i, dirty_i,
             wb_gnt_i, wb_done_i, inval_gnt_i,
      output flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_idx_o,
             wb_way_o, inval_req_o, inval_idx_o, wb_count_o
   );

   // controller / cache view
   modport slave (
      output flush_i, tag_gnt_i, tag_rvalid_i, valid_i, dirty_i,
             wb_gnt_i, wb_done_i, inval_gnt_i,
      input  flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_req_o, wb_idx_o,
             wb_way_o, inval_req_o, inval_idx_o, wb_count_o
   );
endinterface

// File: rtl/dcache_flush_seq.sv
// rtl/dcache_flush_seq.sv - walks every D$ set, writes back dirty ways, invalidates, then acks the flush
module dcache_flush_seq #(
   parameter  int NUM_SETS = 256,
   parameter  int NUM_WAYS = 8,
   localparam int IDX_W    = $clog2(NUM_SETS),
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   dcache_flush_seq_if.master bus
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_READ_TAG   = 3'd1;
   localparam logic [2:0] S_WAIT_TAG   = 3'd2;
   localparam logic [2:0] S_WRITEBACK  = 3'd3;
   localparam logic [2:0] S_WAIT_WB    = 3'd4;
   localparam logic [2:0] S_INVALIDATE = 3'd5;
   localparam logic [2:0] S_NEXT_SET   = 3'd6;
   localparam logic [2:0] S_DONE       = 3'd7;

   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_SETS - 1);
   localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
   localparam logic [NUM_WAYS-1:0] MASK_ONE = NUM_WAYS'(1);
   localparam logic [15:0]         CNT_MAX  = 16'hFFFF;

   logic [2:0]          state_q,    state_d;
   logic [IDX_W-1:0]    idx_q,      idx_d;
   logic [NUM_WAYS-1:0] mask_q,     mask_d;
   logic [15:0]         wb_count_q, wb_count_d;
   logic                holdoff_q,  holdoff_d;
   logic [WAY_W-1:0]    low_way;

   // lowest pending dirty way; scanning downward lets the last hit (lowest index) win
   always_comb begin
      low_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (mask_q[w]) begin
            low_way = WAY_W'(w);
         end
      end
   end

   // next-state and datapath updates for the set walk
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mask_d     = mask_q;
      wb_count_d = wb_count_q;
      holdoff_d  = holdoff_q;
      case (state_q)
         S_IDLE: begin
            // holdoff only masks the single IDLE cycle right after DONE,
            // covering the controller's registered flush level still being high
            holdoff_d = 1'b0;
            if (bus.flush_i && !holdoff_q) begin
               idx_d      = '0;
               wb_count_d = '0;
               state_d    = S_READ_TAG;
            end
         end
         S_READ_TAG: begin
            if (bus.tag_gnt_i) begin
               state_d = S_WAIT_TAG;
            end
         end
         S_WAIT_TAG: begin
            if (bus.tag_rvalid_i) begin
               mask_d  = bus.valid_i & bus.dirty_i;
               state_d = ((bus.valid_i & bus.dirty_i) != '0) ? S_WRITEBACK : S_INVALIDATE;
            end
         end
         S_WRITEBACK: begin
            if (bus.wb_gnt_i) begin
               state_d = S_WAIT_WB;
            end
         end
         S_WAIT_WB: begin
            if (bus.wb_done_i) begin
               // x & (x-1) drops exactly the lowest set bit, i.e. the way just written back
               mask_d = mask_q & (mask_q - MASK_ONE);
               if (wb_count_q != CNT_MAX) begin
                  wb_count_d = wb_count_q + 16'd1;
               end
               state_d = ((mask_q & (mask_q - MASK_ONE)) != '0) ? S_WRITEBACK : S_INVALIDATE;
            end
         end
         S_INVALIDATE: begin
            if (bus.inval_gnt_i) begin
               state_d = S_NEXT_SET;
            end
         end
         S_NEXT_SET: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               state_d = S_READ_TAG;
            end
         end
         S_DONE: begin
            holdoff_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state registers; reset aborts any walk in progress without acking
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         mask_q     <= '0;
         wb_count_q <= '0;
         holdoff_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mask_q     <= mask_d;
         wb_count_q <= wb_count_d;
         holdoff_q  <= holdoff_d;
      end
   end

   // all requests decode straight from the state so they hold steady through grant stalls
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.flush_ack_o = (state_q == S_DONE);
   assign bus.tag_req_o   = (state_q == S_READ_TAG);
   assign bus.tag_idx_o   = idx_q;
   assign bus.wb_req_o    = (state_q == S_WRITEBACK);
   assign bus.wb_idx_o    = idx_q;
   assign bus.wb_way_o    = low_way;
   assign bus.inval_req_o = (state_q == S_INVALIDATE);
   assign bus.inval_idx_o = idx_q;
   assign bus.wb_count_o  = wb_count_q;

endmodule
